pipe_stage_elastic: RTL and testbench

- Parametrised, elastic successor to the fixed enable/reset pipeline register used between the IF/ID/EX/MEM/WB stages.
- Carries a WIDTH-bit stage payload with valid/ready handshaking, so a stalled downstream stage back-pressures upstream without a global stall wire.
- Provides a synchronous flush for branch/jump squash.
- Optional two-entry skid mode gives full throughput with a registered in_ready, breaking the hazard-to-IF combinational path.

---
 rtl/cpu_pipe_pkg.sv | 16 +
 rtl/pipe_data_reg.sv | 29 ++
 rtl/pipe_stage_elastic.sv | 131 +++++++++++++
 tb/tb_pipe_stage_elastic.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared state encoding and stage payload widths for the CPU pipeline registers
package cpu_pipe_pkg;

    // Occupancy of an elastic stage; the encoding doubles as the entry count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // Payload widths of the inter-stage registers, kept here so every instance agrees
    localparam int ID_EX_WIDTH  = 154;
    localparam int EX_MEM_WIDTH = 72;
    localparam int MEM_WB_WIDTH = 71;

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - payload register with async reset and sync clear/load
module pipe_data_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Clear wins over load so a squash never lets a payload slip in
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= RESET_VAL;
        end else if (clr_i) begin
            data_q <= RESET_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline stage with flush and optional skid entry
module pipe_stage_elastic
    import cpu_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    generate
        if (WIDTH < 1 || (SKID != 0 && SKID != 1)) begin : g_bad_param
            $error("pipe_stage_elastic: WIDTH must be >= 1 and SKID must be 0 or 1");
        end
    endgenerate

    pipe_state_e      state_q;
    logic             in_ready_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // in_ready_q also acts as an "out of reset" flag, so the non-skid form stays low during reset
    assign in_ready  = (SKID != 0) ? in_ready_q : (in_ready_q & (out_ready | ~out_valid));
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign main_d    = main_from_skid ? skid_q : in_data;

    // Decide which entry captures data this cycle from the current occupancy and handshakes
    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            ST_EMPTY: main_load = in_xfer;
            ST_ONE: begin
                if (in_xfer) begin
                    if (out_xfer || SKID == 0) begin
                        main_load = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                    end
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Occupancy FSM; in_ready_q is registered so out_ready never reaches upstream combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= 1'b1;
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) state_q <= ST_ONE;
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer && SKID != 0) begin
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (!in_xfer && out_xfer) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_q <= ST_ONE;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_reg (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (flush),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid_reg (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (flush),
        .load_i (skid_load),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed self-checking bench for pipe_stage_elastic (skid and non-skid)
module tb_pipe_stage_elastic;

    logic        clk;
    logic        rst;

    logic        f1, iv1, ir1, ov1, or1;
    logic [31:0] id1, od1;
    logic [1:0]  oc1;

    logic        f0, iv0, ir0, ov0, or0;
    logic [7:0]  id0, od0;
    logic [1:0]  oc0;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_elastic #(.WIDTH(32), .SKID(1), .RESET_VAL(32'h0)) u_skid (
        .clk(clk), .reset(rst), .flush(f1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(oc1)
    );

    pipe_stage_elastic #(.WIDTH(8), .SKID(0), .RESET_VAL(8'hA5)) u_noskid (
        .clk(clk), .reset(rst), .flush(f0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(oc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        f1 = 0; iv1 = 0; or1 = 0; id1 = '0;
        f0 = 0; iv0 = 0; or0 = 0; id0 = '0;
        #1;
        chk("rst_ir1", ir1, 1'b0);
        chk("rst_ov1", ov1, 1'b0);
        chk("rst_oc1", oc1, 2'd0);
        chk("rst_od1", od1, 32'h0);
        chk("rst_ir0", ir0, 1'b0);
        chk("rst_od0", od0, 8'hA5);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rel_ir1_before_edge", ir1, 1'b0);
        tick();
        chk("rel_ir1_after_edge", ir1, 1'b1);
        chk("rel_ir0_after_edge", ir0, 1'b1);

        // Stream 1..8 with out_ready held high
        or1 = 1; iv1 = 1;
        for (int i = 1; i <= 8; i++) begin
            id1 = i;
            tick();
            chk("stream_ov", ov1, 1'b1);
            chk("stream_od", od1, i);
            chk("stream_ir", ir1, 1'b1);
            chk("stream_oc", oc1, 2'd1);
        end
        iv1 = 0;
        tick();
        chk("stream_end_ov", ov1, 1'b0);
        chk("stream_end_oc", oc1, 2'd0);
        chk("stream_end_od", od1, 32'd8);

        // Back-pressure fill to two entries, then drain in order
        or1 = 0; iv1 = 1; id1 = 32'hAAAA0001;
        tick();
        chk("bp_a_od", od1, 32'hAAAA0001);
        chk("bp_a_oc", oc1, 2'd1);
        chk("bp_a_ir", ir1, 1'b1);
        id1 = 32'hAAAA0002;
        tick();
        chk("bp_full_oc", oc1, 2'd2);
        chk("bp_full_ir", ir1, 1'b0);
        chk("bp_full_od", od1, 32'hAAAA0001);
        chk("bp_full_ov", ov1, 1'b1);
        id1 = 32'hDEAD0000;
        tick();
        chk("bp_hold_od", od1, 32'hAAAA0001);
        chk("bp_hold_oc", oc1, 2'd2);
        or1 = 1; id1 = 32'h00000099;
        tick();
        chk("bp_drain_b_od", od1, 32'hAAAA0002);
        chk("bp_drain_b_oc", oc1, 2'd1);
        chk("bp_drain_ir", ir1, 1'b1);
        iv1 = 0;
        tick();
        chk("bp_empty_oc", oc1, 2'd0);
        chk("bp_empty_ov", ov1, 1'b0);
        chk("bp_empty_od", od1, 32'hAAAA0002);

        // Flush while full, with an incoming payload in the flush cycle
        or1 = 0; iv1 = 1; id1 = 32'hAAAA0001;
        tick();
        id1 = 32'hAAAA0002;
        tick();
        chk("fl_pre_oc", oc1, 2'd2);
        f1 = 1; id1 = 32'hCCCC0003;
        tick();
        chk("fl_ov", ov1, 1'b0);
        chk("fl_oc", oc1, 2'd0);
        chk("fl_od", od1, 32'h0);
        chk("fl_ir", ir1, 1'b1);
        f1 = 0; iv1 = 0;
        tick();
        chk("fl_after_ov", ov1, 1'b0);
        chk("fl_after_od", od1, 32'h0);

        // Same-cycle input and output while holding one entry
        or1 = 0; iv1 = 1; id1 = 32'h0000000D;
        tick();
        chk("same_d_od", od1, 32'h0000000D);
        or1 = 1; id1 = 32'h0000000E;
        tick();
        chk("same_e_od", od1, 32'h0000000E);
        chk("same_e_oc", oc1, 2'd1);
        chk("same_e_ov", ov1, 1'b1);
        iv1 = 0;
        tick();
        chk("same_end_oc", oc1, 2'd0);

        // Asynchronous reset between edges while one entry is held
        or1 = 0; iv1 = 1; id1 = 32'h00001234;
        tick();
        chk("ar_pre_oc", oc1, 2'd1);
        iv1 = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_ov", ov1, 1'b0);
        chk("ar_oc", oc1, 2'd0);
        chk("ar_ir", ir1, 1'b0);
        chk("ar_od", od1, 32'h0);
        tick();
        chk("ar_held_ir", ir1, 1'b0);
        rst = 1'b0;
        #1;
        chk("ar_rel_ir_before_edge", ir1, 1'b0);
        tick();
        chk("ar_rel_ir_after_edge", ir1, 1'b1);

        // Non-skid stage with toggling out_ready and continuous input
        iv0 = 1; or0 = 1; id0 = 8'h10;
        #1;
        chk("ns_c0_ir", ir0, 1'b1);
        tick();
        or0 = 0; id0 = 8'h11;
        #1;
        chk("ns_c1_od", od0, 8'h10);
        chk("ns_c1_ir", ir0, 1'b0);
        tick();
        or0 = 1;
        #1;
        chk("ns_c2_od", od0, 8'h10);
        chk("ns_c2_ir", ir0, 1'b1);
        tick();
        or0 = 0; id0 = 8'h12;
        #1;
        chk("ns_c3_od", od0, 8'h11);
        chk("ns_c3_ir", ir0, 1'b0);
        tick();
        or0 = 1;
        #1;
        chk("ns_c4_od", od0, 8'h11);
        chk("ns_c4_ir", ir0, 1'b1);
        tick();
        or0 = 0; id0 = 8'h13;
        #1;
        chk("ns_c5_od", od0, 8'h12);
        chk("ns_c5_ir", ir0, 1'b0);
        tick();
        or0 = 1;
        #1;
        chk("ns_c6_od", od0, 8'h12);
        tick();
        or0 = 0; iv0 = 0;
        #1;
        chk("ns_c7_od", od0, 8'h13);
        chk("ns_c7_ov", ov0, 1'b1);
        chk("ns_c7_oc", oc0, 2'd1);
        tick();
        or0 = 1;
        #1;
        chk("ns_c8_ir", ir0, 1'b1);
        tick();
        or0 = 0;
        #1;
        chk("ns_c9_ov", ov0, 1'b0);
        chk("ns_c9_ir", ir0, 1'b1);
        chk("ns_c9_od", od0, 8'h13);
        chk("ns_c9_oc", oc0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
